// File: rtl/data_bus_bridge.sv
// data_bus_bridge: turns the core's single-cycle load/store strobes into a
// valid/ready request plus a one-pulse response, stalling the core meanwhile.
// Optional feature macro: BUS_TIMEOUT_EN adds a watchdog that aborts a
// transaction after TIMEOUT_CYCLES cycles in REQ+RESP and sets sticky bus_error.
module data_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] core_address,
    input  logic [31:0] core_write_data,
    input  logic [3:0]  core_byte_enable,
    input  logic        core_read_enable,
    input  logic        core_write_enable,
    output logic [31:0] core_read_data,
    output logic        core_stall,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_write,
    output logic [31:0] bus_req_address,
    output logic [31:0] bus_req_data,
    output logic [3:0]  bus_req_strobe,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_data,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      r_state;
    logic [31:0] r_rdata;
    logic        r_valid;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_strb;

    logic        w_start;
    logic        w_timeout;

    assign w_start = core_read_enable | core_write_enable;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_error;
    logic       w_expire;

    // The count equals the number of cycles already spent in REQ+RESP, so
    // hitting LIMIT means this is the last allowed cycle.
    assign w_expire  = (r_cnt == LIMIT);
    // A response on the expiry cycle completes normally instead of aborting.
    assign w_timeout = w_expire &&
                       ((r_state == REQ) || (r_state == RESP && !bus_resp_valid));
    assign bus_error = r_error;

    // Watchdog counter: cleared when a request is launched, runs in REQ/RESP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 8'd0;
        end else if (r_state == IDLE && w_start) begin
            r_cnt <= 8'd0;
        end else if (r_state == REQ || r_state == RESP) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    // Without the watchdog the flag is constant 0 over the legal parameter range.
    assign bus_error = (TIMEOUT_CYCLES == 0);
`endif

    // Transaction FSM with registered request payload and load-data return.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_rdata <= 32'h0;
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= 32'h0;
            r_data  <= 32'h0;
            r_strb  <= 4'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        // Store wins when both strobes are raised.
                        r_write <= core_write_enable;
                        r_addr  <= core_address & 32'hFFFF_FFFC;
                        r_data  <= core_write_data;
                        r_strb  <= core_write_enable ? core_byte_enable : 4'hF;
                        r_valid <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (w_timeout) begin
                        r_valid <= 1'b0;
                        if (!r_write) r_rdata <= 32'h0;
                        r_state <= DONE;
                    end else if (bus_req_ready) begin
                        r_valid <= 1'b0;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (bus_resp_valid) begin
                        if (!r_write) r_rdata <= bus_resp_data;
                        r_state <= DONE;
                    end else if (w_timeout) begin
                        if (!r_write) r_rdata <= 32'h0;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stall is combinational so the core freezes in the same cycle it issues;
    // gating with reset_n releases the core immediately on an abort by reset.
    assign core_stall = reset_n &&
                        ((r_state == IDLE && w_start) || r_state == REQ || r_state == RESP);

    assign core_read_data  = r_rdata;
    assign bus_req_valid   = r_valid;
    assign bus_req_write   = r_write;
    assign bus_req_address = r_addr;
    assign bus_req_data    = r_data;
    assign bus_req_strobe  = r_strb;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed bench for data_bus_bridge; BUS_TIMEOUT_EN enables watchdog steps.
module tb_data_bus_bridge;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] core_address;
    logic [31:0] core_write_data;
    logic [3:0]  core_byte_enable;
    logic        core_read_enable;
    logic        core_write_enable;
    logic [31:0] core_read_data;
    logic        core_stall;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_write;
    logic [31:0] bus_req_address;
    logic [31:0] bus_req_data;
    logic [3:0]  bus_req_strobe;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_data;
    logic        bus_error;

    int checks   = 0;
    int failures = 0;

    data_bus_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .core_address(core_address), .core_write_data(core_write_data),
        .core_byte_enable(core_byte_enable), .core_read_enable(core_read_enable),
        .core_write_enable(core_write_enable), .core_read_data(core_read_data),
        .core_stall(core_stall), .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready), .bus_req_write(bus_req_write),
        .bus_req_address(bus_req_address), .bus_req_data(bus_req_data),
        .bus_req_strobe(bus_req_strobe), .bus_resp_valid(bus_resp_valid),
        .bus_resp_data(bus_resp_data), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        core_address = 32'h0; core_write_data = 32'h0; core_byte_enable = 4'h0;
        core_read_enable = 1'b0; core_write_enable = 1'b0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = 32'h0;
        #12;
        chk("rst_rdata", core_read_data, 32'h0);
        chk("rst_valid", {31'h0, bus_req_valid}, 32'h0);
        chk("rst_stall", {31'h0, core_stall}, 32'h0);
        chk("rst_addr", bus_req_address, 32'h0);
        chk("rst_strobe", {28'h0, bus_req_strobe}, 32'h0);
        chk("rst_error", {31'h0, bus_error}, 32'h0);
        tick(); reset_n = 1'b1; tick();

        // Load, zero wait states
        core_address = 32'h0000_1006; core_read_enable = 1'b1; #1;
        chk("ld_stall_C", {31'h0, core_stall}, 32'h1);
        chk("ld_valid_C", {31'h0, bus_req_valid}, 32'h0);
        tick(); bus_req_ready = 1'b1; #1;
        chk("ld_valid_C1", {31'h0, bus_req_valid}, 32'h1);
        chk("ld_addr", bus_req_address, 32'h0000_1004);
        chk("ld_strobe", {28'h0, bus_req_strobe}, 32'hF);
        chk("ld_write", {31'h0, bus_req_write}, 32'h0);
        chk("ld_stall_C1", {31'h0, core_stall}, 32'h1);
        tick(); bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 32'hCAFEBABE; #1;
        chk("ld_stall_C2", {31'h0, core_stall}, 32'h1);
        chk("ld_valid_C2", {31'h0, bus_req_valid}, 32'h0);
        tick(); bus_resp_valid = 1'b0; #1;
        chk("ld_stall_C3", {31'h0, core_stall}, 32'h0);
        chk("ld_rdata", core_read_data, 32'hCAFEBABE);
        tick(); core_read_enable = 1'b0; #1;
        chk("ld_idle_stall", {31'h0, core_stall}, 32'h0);

        // Store with 3 cycles of backpressure
        core_address = 32'h20; core_write_data = 32'h11223344; core_byte_enable = 4'b0011;
        core_write_enable = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("st_valid_hold", {31'h0, bus_req_valid}, 32'h1);
            chk("st_addr_hold", bus_req_address, 32'h20);
            chk("st_data_hold", bus_req_data, 32'h11223344);
            chk("st_strobe_hold", {28'h0, bus_req_strobe}, 32'h3);
            chk("st_write", {31'h0, bus_req_write}, 32'h1);
            chk("st_stall_hold", {31'h0, core_stall}, 32'h1);
            tick();
        end
        bus_req_ready = 1'b1; tick();
        bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 32'h99999999; tick();
        bus_resp_valid = 1'b0; #1;
        chk("st_done_stall", {31'h0, core_stall}, 32'h0);
        chk("st_rdata_keep", core_read_data, 32'hCAFEBABE);
        tick(); core_write_enable = 1'b0;

        // Both enables high, stray responses in IDLE and REQ
        core_address = 32'h44; core_write_data = 32'hA5A5A5A5; core_byte_enable = 4'b1100;
        core_read_enable = 1'b1; core_write_enable = 1'b1;
        bus_resp_valid = 1'b1; bus_resp_data = 32'h77777777;
        tick();
        chk("both_write", {31'h0, bus_req_write}, 32'h1);
        chk("both_strobe", {28'h0, bus_req_strobe}, 32'hC);
        tick();
        chk("both_still_req", {31'h0, bus_req_valid}, 32'h1);
        bus_req_ready = 1'b1; tick();
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; #1;
        chk("both_resp_stall", {31'h0, core_stall}, 32'h1);
        chk("both_resp_valid", {31'h0, bus_req_valid}, 32'h0);
        tick();
        chk("same_cyc_resp_ignored", {31'h0, core_stall}, 32'h1);
        bus_resp_valid = 1'b1; bus_resp_data = 32'h55; tick();
        bus_resp_valid = 1'b0; #1;
        chk("both_done_stall", {31'h0, core_stall}, 32'h0);
        chk("both_rdata_keep", core_read_data, 32'hCAFEBABE);
        tick(); core_read_enable = 1'b0; core_write_enable = 1'b0;

        // Reset asserted mid-RESP
        core_address = 32'h40; core_read_enable = 1'b1; tick();
        bus_req_ready = 1'b1; tick();
        bus_req_ready = 1'b0; #2;
        reset_n = 1'b0; core_read_enable = 1'b0; #1;
        chk("mid_rst_valid", {31'h0, bus_req_valid}, 32'h0);
        chk("mid_rst_stall", {31'h0, core_stall}, 32'h0);
        chk("mid_rst_rdata", core_read_data, 32'h0);
        chk("mid_rst_addr", bus_req_address, 32'h0);
        tick(); reset_n = 1'b1; tick();
        core_address = 32'h8; core_read_enable = 1'b1; tick();
        bus_req_ready = 1'b1; tick();
        bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 32'h12345678; tick();
        bus_resp_valid = 1'b0; #1;
        chk("post_rst_rdata", core_read_data, 32'h12345678);
        chk("post_rst_stall", {31'h0, core_stall}, 32'h0);
        tick(); core_read_enable = 1'b0;

`ifdef BUS_TIMEOUT_EN
        // Timeout: no response, DONE 16 cycles after entering REQ
        core_address = 32'h100; core_read_enable = 1'b1; tick();
        bus_req_ready = 1'b1; tick();
        bus_req_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("to_stall_C16", {31'h0, core_stall}, 32'h1);
        chk("to_error_C16", {31'h0, bus_error}, 32'h0);
        tick();
        chk("to_stall_C17", {31'h0, core_stall}, 32'h0);
        chk("to_rdata_zero", core_read_data, 32'h0);
        chk("to_error_set", {31'h0, bus_error}, 32'h1);
        tick(); core_read_enable = 1'b0;
        core_address = 32'h104; core_read_enable = 1'b1; tick();
        bus_req_ready = 1'b1; tick();
        bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 32'h0BADF00D; tick();
        bus_resp_valid = 1'b0; #1;
        chk("to_next_rdata", core_read_data, 32'h0BADF00D);
        chk("to_error_sticky", {31'h0, bus_error}, 32'h1);
        tick(); core_read_enable = 1'b0;
        reset_n = 1'b0; #1;
        chk("to_error_rst", {31'h0, bus_error}, 32'h0);
        tick(); reset_n = 1'b1; tick();

        // Response on the expiry cycle wins
        core_address = 32'h200; core_read_enable = 1'b1; tick();
        bus_req_ready = 1'b1; tick();
        bus_req_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        bus_resp_valid = 1'b1; bus_resp_data = 32'hDEADBEEF; tick();
        bus_resp_valid = 1'b0; #1;
        chk("exp_stall", {31'h0, core_stall}, 32'h0);
        chk("exp_rdata", core_read_data, 32'hDEADBEEF);
        chk("exp_error", {31'h0, bus_error}, 32'h0);
        tick(); core_read_enable = 1'b0;
`else
        // No watchdog: waits indefinitely for the response
        core_address = 32'h300; core_read_enable = 1'b1; tick();
        bus_req_ready = 1'b1; tick();
        bus_req_ready = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("nto_stall", {31'h0, core_stall}, 32'h1);
        chk("nto_error", {31'h0, bus_error}, 32'h0);
        bus_resp_valid = 1'b1; bus_resp_data = 32'h600DF00D; tick();
        bus_resp_valid = 1'b0; #1;
        chk("nto_rdata", core_read_data, 32'h600DF00D);
        chk("nto_done_stall", {31'h0, core_stall}, 32'h0);
        tick(); core_read_enable = 1'b0;
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_bus_bridge.md
# data_bus_bridge

Sits directly downstream of the single-cycle RISC-V core's data-memory port. Converts the core's one-cycle read/write strobes into a valid/ready request channel plus a response channel toward external memory. It holds the core in a stall, combinationally, until the transaction completes. An optional timeout watchdog aborts transactions whose response never arrives.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 16: cycles spent in REQ+RESP before abort. Legal range is 2..255.

Ports:
- clock  in  1: rising-edge clock.
- reset_n  in  1: asynchronous, active-low reset.
- core_address  in  32: byte address from the core's ALU result.
- core_write_data  in  32: lane-aligned store data.
- core_byte_enable  in  4: store byte lanes.
- core_read_enable  in  1: load request.
- core_write_enable  in  1: store request.
- core_read_data  out  32: load data returned to the core.
- core_stall  out  1: hold the core's PC and register writeback.
- bus_req_valid  out  1: request valid.
- bus_req_ready  in  1: memory accepts the request.
- bus_req_write  out  1: 1 = store, 0 = load.
- bus_req_address  out  32: word address, with bits [1:0] forced to 0.
- bus_req_data  out  32: store data.
- bus_req_strobe  out  4: byte strobes. Forced to 4'hF on loads.
- bus_resp_valid  in  1: response or ack valid, single-cycle pulse.
- bus_resp_data  in  32: load data, ignored for stores.
- bus_error  out  1: sticky timeout flag.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - When core_read_enable or core_write_enable is high, capture address, data, strobes and direction into registers, then go to REQ.
  - If both enables are high, the store wins.
- REQ:
  - bus_req_valid = 1. The payload comes from the capture registers and stays stable until the handshake.
  - On bus_req_ready, go to RESP.
- RESP:
  - On bus_resp_valid, latch bus_resp_data into core_read_data (loads only; stores leave it unchanged), then go to DONE.
- DONE:
  - core_stall = 0. The core retires the instruction this cycle and re-presents the same strobes.
  - Strobes are ignored in DONE. Always return to IDLE.
- core_stall is combinational: (IDLE and (read_enable or write_enable)) or REQ or RESP.
- bus_resp_valid outside RESP is ignored. bus_req_ready outside REQ is ignored.
- core_read_data holds its last value between transactions.
- Reset values:
  - state IDLE.
  - core_read_data = 0.
  - bus_req_valid = 0, bus_req_write = 0, bus_req_address = 0, bus_req_data = 0, bus_req_strobe = 0.
  - bus_error = 0.
  - core_stall follows its equation, so it is 0 when no strobe is present.
- Reset asserted mid-transaction: the transaction is abandoned immediately and bus_req_valid drops asynchronously. Memory must tolerate the dropped request.

## Timing
- A request is seen in IDLE at cycle C:
  - C: stall = 1.
  - C+1: REQ, valid = 1.
  - With ready at C+1 and resp_valid at C+2, DONE is at C+3 and the instruction retires at C+3.
- Minimum stall is 3 cycles. Each cycle of ready or response delay adds one cycle.
- bus_resp_valid in the same cycle as bus_req_ready is ignored. A response is accepted only from RESP.
- Back-to-back memory instructions: DONE → IDLE → new capture. There is a 1-cycle gap, with IDLE at C+4.

## Configuration
- BUS_TIMEOUT_EN defined:
  - An 8-bit counter clears on IDLE→REQ and increments each cycle in REQ or RESP.
  - When the count reaches TIMEOUT_CYCLES without completing, go to DONE, force core_read_data = 32'h0 for loads, drop bus_req_valid, and set bus_error.
  - bus_error clears only on reset.
  - A response arriving in the same cycle as expiry wins: data is latched and no error is raised.
- BUS_TIMEOUT_EN undefined: no counter; the block waits indefinitely; bus_error is tied to 0.

## Test plan
- Load, zero wait states. Drive read_enable with address 0x0000_1006, ready at C+1, resp_data = 0xCAFEBABE at C+2.
  - bus_req_address = 0x0000_1004 and strobe = 4'hF.
  - stall is high during C..C+2 and low at C+3.
  - core_read_data = 0xCAFEBABE at C+3.
- Store with backpressure. Write to 0x20 with data 0x11223344 and byte_enable 4'b0011; ready held low for 3 cycles.
  - bus_req_valid stays high with a stable payload.
  - write = 1 and strobe = 4'b0011.
  - core_read_data is unchanged.
- Both enables high. The bus sees write = 1. Stray resp_valid pulses while in IDLE or REQ are ignored.
- Reset mid-RESP. Assert reset_n low during RESP.
  - valid and stall drop at once and all outputs take their reset values.
  - After release, a new load completes normally.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and no response.
  - DONE is entered exactly 16 cycles after entering REQ, with core_read_data = 0 and bus_error = 1.
  - bus_error stays 1 through a later successful transaction.
- BUS_TIMEOUT_EN with the response arriving on the expiry cycle. Data is latched and bus_error stays 0.
